alu_seq_unit: RTL

- Parametrised, registered successor of the combinational 8-bit ALU result mux in the PLC core datapath.
- Generalises data width and adds internal add/sub with carry, a multi-cycle iterative multiplier, and a comparator flag register with PLC-style accumulate modes (load/AND/OR).
- Uses a start/busy/valid handshake so the core sequencer can stall on multi-cycle ops.
- Sits between the core register file and the writeback/branch-condition logic.

---
 rtl/alu_seq_unit.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_unit.sv
// ---------------------------------------------------------------------------
// alu_seq_unit
//   Registered ALU for the PLC core datapath. It handles logic, shift/rotate,
//   add/sub with carry, and unsigned compares in one cycle. A shift-add
//   multiplier (MULL/MULH) takes DATA_W+1 cycles from start to valid. A
//   comparator flag register accumulates compare results in load/AND/OR mode.
//
//   Optional build macro: ALU_SIGNED_CMP_EN
//     When it is defined:
//       - the GT/GE/LE/LT compares are two's-complement signed;
//       - SHR1 (0101) and SHR-by-B (10011) fill from the sign bit;
//       - MULH returns the signed high half of the product.
//     When it is not defined, all of these operations are unsigned.
//
//   Ports:
//     CLK             system clock, all state on the rising edge
//     CPU_Reset       synchronous active-high reset
//     ALU_Start       1-cycle pulse that captures the opcode and operands
//     ALU_OPCode[4:0] operation select
//     ALU_A, ALU_B    operands (DATA_W bits)
//     CMPREG_EN       enables the flag update on compare ops
//     CMP_Mode[1:0]   flag mode: 00 load, 01 AND, 10 OR, 11 hold
//     ALU_Result      registered result, held until the next completion
//     ALU_Valid       1-cycle pulse when the result and flags update
//     ALU_Busy        high while a multiply is iterating
//     ALU_Carry       add carry / sub borrow, 0 for other ops
//     ALU_Zero        result == 0, updated with ALU_Valid
//     ALU_CompareFlag comparator flag register
// ---------------------------------------------------------------------------
module alu_seq_unit #(
  parameter int DATA_W    = 8,
  parameter int MUL_CNT_W = $clog2(DATA_W) + 1
) (
  input  logic              CLK,
  input  logic              CPU_Reset,
  input  logic              ALU_Start,
  input  logic [4:0]        ALU_OPCode,
  input  logic [DATA_W-1:0] ALU_A,
  input  logic [DATA_W-1:0] ALU_B,
  input  logic              CMPREG_EN,
  input  logic [1:0]        CMP_Mode,
  output logic [DATA_W-1:0] ALU_Result,
  output logic              ALU_Valid,
  output logic              ALU_Busy,
  output logic              ALU_Carry,
  output logic              ALU_Zero,
  output logic              ALU_CompareFlag
);

  localparam int SH_W   = $clog2(DATA_W);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0]    result_reg;
  logic                 valid_reg;
  logic                 carry_reg;
  logic                 zero_reg;
  logic                 flag_reg;
  logic [PROD_W-1:0]    acc_reg;
  logic [DATA_W-1:0]    mcand_reg;
  logic                 neg_reg;
  logic                 high_reg;
  logic [MUL_CNT_W-1:0] cnt_reg;

  logic accept;
  logic is_mul_op;
  logic mul_last;

  // DONE behaves like IDLE for new starts; only an iterating multiply blocks.
  assign accept    = ALU_Start && (state_reg != MUL);
  assign is_mul_op = (ALU_OPCode == 5'b10000) || (ALU_OPCode == 5'b10001);
  assign mul_last  = (cnt_reg == MUL_CNT_W'(DATA_W - 1));

  // ---------------- single-cycle datapath ----------------
  logic [DATA_W:0]   add_full;
  logic [DATA_W:0]   sub_full;
  logic [SH_W-1:0]   sh_amt;
  logic [DATA_W-1:0] shr1;
  logic [DATA_W-1:0] shrn;
  logic              a_lt_b;
  logic              a_gt_b;

  // The extra top bit of each sum is the carry (add) or the borrow (sub).
  assign add_full = {1'b0, ALU_A} + {1'b0, ALU_B};
  assign sub_full = {1'b0, ALU_A} - {1'b0, ALU_B};
  assign sh_amt   = ALU_B[SH_W-1:0];

`ifdef ALU_SIGNED_CMP_EN
  assign a_lt_b = $signed(ALU_A) < $signed(ALU_B);
  assign a_gt_b = $signed(ALU_A) > $signed(ALU_B);
  assign shr1   = {ALU_A[DATA_W-1], ALU_A[DATA_W-1:1]};
  assign shrn   = $signed(ALU_A) >>> sh_amt;
`else
  assign a_lt_b = ALU_A < ALU_B;
  assign a_gt_b = ALU_A > ALU_B;
  assign shr1   = {1'b0, ALU_A[DATA_W-1:1]};
  assign shrn   = ALU_A >> sh_amt;
`endif

  logic [DATA_W-1:0] op_result;
  logic              op_carry;
  logic              op_is_cmp;
  logic              cmp_bit;

  always_comb begin
    op_result = '0;
    op_carry  = 1'b0;
    op_is_cmp = 1'b0;
    cmp_bit   = 1'b0;
    case (ALU_OPCode)
      5'b00000: op_result = ALU_A & ALU_B;
      5'b00001: op_result = ALU_A | ALU_B;
      5'b00010: op_result = ~ALU_A;
      5'b00011: op_result = ALU_A ^ ALU_B;
      5'b00100: op_result = {ALU_A[DATA_W-2:0], 1'b0};
      5'b00101: op_result = shr1;
      5'b00110: op_result = {ALU_A[DATA_W-2:0], ALU_A[DATA_W-1]};
      5'b00111: op_result = {ALU_A[0], ALU_A[DATA_W-1:1]};
      5'b01000: begin
        op_result = add_full[DATA_W-1:0];
        op_carry  = add_full[DATA_W];
      end
      5'b01001: begin
        op_result = sub_full[DATA_W-1:0];
        op_carry  = sub_full[DATA_W];
      end
      5'b01010: begin op_is_cmp = 1'b1; cmp_bit = (ALU_A == ALU_B); end
      5'b01011: begin op_is_cmp = 1'b1; cmp_bit = a_gt_b;           end
      5'b01100: begin op_is_cmp = 1'b1; cmp_bit = !a_lt_b;          end
      5'b01101: begin op_is_cmp = 1'b1; cmp_bit = (ALU_A != ALU_B); end
      5'b01110: begin op_is_cmp = 1'b1; cmp_bit = !a_gt_b;          end
      5'b01111: begin op_is_cmp = 1'b1; cmp_bit = a_lt_b;           end
      5'b10010: op_result = ALU_A << sh_amt;
      5'b10011: op_result = shrn;
      default:  op_result = '0;  // multiply handled separately, rest reserved
    endcase
    if (op_is_cmp) begin
      op_result = {{(DATA_W-1){1'b0}}, cmp_bit};
    end
  end

  logic flag_next;

  always_comb begin
    flag_next = flag_reg;
    if (op_is_cmp && CMPREG_EN) begin
      case (CMP_Mode)
        2'b00:   flag_next = cmp_bit;
        2'b01:   flag_next = flag_reg & cmp_bit;
        2'b10:   flag_next = flag_reg | cmp_bit;
        default: flag_next = flag_reg;
      endcase
    end
  end

  // ---------------- iterative multiplier ----------------
  // Operands are reduced to magnitudes, multiplied unsigned, and the product is
  // negated at the end when the operand signs differ. In the unsigned build
  // the sign terms are tied to zero.
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

`ifdef ALU_SIGNED_CMP_EN
  assign a_neg = ALU_A[DATA_W-1];
  assign b_neg = ALU_B[DATA_W-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  assign a_mag = a_neg ? (~ALU_A + DATA_W'(1)) : ALU_A;
  assign b_mag = b_neg ? (~ALU_B + DATA_W'(1)) : ALU_B;

  // The accumulator low half starts out holding the multiplier. Each step:
  //   - if the low bit is 1, add the multiplicand into the high half;
  //   - shift the whole accumulator right by one.
  // After DATA_W steps the accumulator holds the full product.
  logic [DATA_W:0]   mul_sum;
  logic [PROD_W-1:0] acc_step;
  logic [PROD_W-1:0] prod;
  logic [DATA_W-1:0] mul_result;

  assign mul_sum    = {1'b0, acc_reg[PROD_W-1:DATA_W]}
                    + (acc_reg[0] ? {1'b0, mcand_reg} : {(DATA_W+1){1'b0}});
  assign acc_step   = {mul_sum, acc_reg[DATA_W-1:1]};
  assign prod       = neg_reg ? (~acc_step + PROD_W'(1)) : acc_step;
  assign mul_result = high_reg ? prod[PROD_W-1:DATA_W] : prod[DATA_W-1:0];

  // ---------------- control FSM ----------------
  always_ff @(posedge CLK) begin
    if (CPU_Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: state_next = (accept && is_mul_op) ? MUL : IDLE;
      MUL:        if (mul_last) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // ---------------- result / flag registers ----------------
  always_ff @(posedge CLK) begin
    if (CPU_Reset) begin
      result_reg <= '0;
      valid_reg  <= 1'b0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      flag_reg   <= 1'b0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      neg_reg    <= 1'b0;
      high_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      valid_reg <= 1'b0;
      if (state_reg == MUL) begin
        acc_reg <= acc_step;
        cnt_reg <= cnt_reg + MUL_CNT_W'(1);
        if (mul_last) begin
          result_reg <= mul_result;
          carry_reg  <= 1'b0;
          zero_reg   <= (mul_result == '0);
          valid_reg  <= 1'b1;
        end
      end else if (accept) begin
        if (is_mul_op) begin
          acc_reg   <= {{DATA_W{1'b0}}, b_mag};
          mcand_reg <= a_mag;
          neg_reg   <= a_neg ^ b_neg;
          high_reg  <= ALU_OPCode[0];
          cnt_reg   <= '0;
        end else begin
          result_reg <= op_result;
          carry_reg  <= op_carry;
          zero_reg   <= (op_result == '0);
          valid_reg  <= 1'b1;
          flag_reg   <= flag_next;
        end
      end
    end
  end

  assign ALU_Result      = result_reg;
  assign ALU_Valid       = valid_reg;
  assign ALU_Busy        = (state_reg == MUL);
  assign ALU_Carry       = carry_reg;
  assign ALU_Zero        = zero_reg;
  assign ALU_CompareFlag = flag_reg;

endmodule
